ioctl_upload_server: RTL



---
 rtl/mist_ioctl_pkg.sv | 24 ++
 rtl/toggle_req_port.sv | 61 ++++++
 rtl/ioctl_upload_server.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mist_ioctl_pkg.sv
// ============================================================================
//  Module   : mist_ioctl_pkg
//  Brief    : Shared ioctl constants and upload FSM state encoding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mist_ioctl_pkg;

   localparam int IOCTL_ADDR_W = 25;

   localparam logic [7:0] IDX_ROM = 8'h00;
   localparam logic [7:0] IDX_UPL = 8'h02;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PAUSE = 2'd1;
   localparam state_t ST_READY = 2'd2;
   localparam state_t ST_WAIT  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/toggle_req_port.sv
// ============================================================================
//  Module   : toggle_req_port
//  Brief    : req/ack toggle handshake with per-access timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module toggle_req_port #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic abort_i,
   input  logic mem_ack_i,
   output logic mem_req_o,
   output logic busy_o,
   output logic done_o,
   output logic timeout_o
);

   logic       req_q, req_d;
   logic       inflight_q, inflight_d;
   logic [7:0] tmo_q, tmo_d;

   // busy also covers a stale ack still owed after a timed-out access
   assign busy_o    = (mem_ack_i != req_q);
   assign done_o    = inflight_q && !busy_o;
   assign timeout_o = inflight_q && busy_o && (tmo_q == 8'd0);
   assign mem_req_o = req_q;

   always_comb begin
      req_d      = req_q;
      inflight_d = inflight_q;
      tmo_d      = tmo_q;
      if (start_i && !busy_o) begin
         req_d      = ~req_q;
         inflight_d = 1'b1;
         tmo_d      = TIMEOUT;
      end else if (abort_i || done_o || timeout_o) begin
         inflight_d = 1'b0;
      end else if (inflight_q && (tmo_q != 8'd0)) begin
         tmo_d = tmo_q - 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q      <= 1'b0;
         inflight_q <= 1'b0;
         tmo_q      <= 8'd0;
      end else begin
         req_q      <= req_d;
         inflight_q <= inflight_d;
         tmo_q      <= tmo_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ioctl_upload_server.sv
// ============================================================================
//  Module   : ioctl_upload_server
//  Brief    : Answers data_io upload reads from memory while pausing the core.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ioctl_upload_server
   import mist_ioctl_pkg::*;
#(
   parameter logic [7:0]  UPL_INDEX    = IDX_UPL,
   parameter logic [23:0] BASE_ADDR    = 24'h000000,
   parameter logic [15:0] LENGTH       = 16'd2048,
   parameter logic [7:0]  FILL         = 8'hFF,
   parameter logic [7:0]  PAUSE_CYCLES = 8'd64,
   parameter logic [7:0]  TIMEOUT      = 8'd200
) (
   input  logic                    clk_sys,
   input  logic                    res_n,
   input  logic                    ioctl_upload,
   input  logic [7:0]              ioctl_index,
   input  logic                    ioctl_rd,
   input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
   output logic [7:0]              ioctl_din,
   output logic                    ioctl_wait,
   output logic                    core_pause,
   output logic                    mem_req,
   input  logic                    mem_ack,
   output logic [23:0]             mem_addr,
   input  logic [7:0]              mem_q,
   output logic                    err
);

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    pend_q, pend_d;
   logic [IOCTL_ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [7:0]              din_q, din_d;
   logic                    wait_q, wait_d;
   logic                    pause_q, pause_d;
   logic                    err_q, err_d;
   logic [23:0]             addr_q, addr_d;

   logic                    session;
   logic                    rd_req;
   logic [IOCTL_ADDR_W-1:0] rd_addr;
   logic                    out_of_range;
   logic                    port_start, port_abort;
   logic                    port_busy, port_done, port_timeout;

   assign session      = ioctl_upload && (ioctl_index == UPL_INDEX);
   assign rd_req       = ioctl_rd || pend_q;
   assign rd_addr      = ioctl_rd ? ioctl_addr : pend_addr_q;
   assign out_of_range = rd_addr >= {{(IOCTL_ADDR_W-16){1'b0}}, LENGTH};

   toggle_req_port #(
      .TIMEOUT (TIMEOUT)
   ) u_port (
      .clk_i     (clk_sys),
      .rst_ni    (res_n),
      .start_i   (port_start),
      .abort_i   (port_abort),
      .mem_ack_i (mem_ack),
      .mem_req_o (mem_req),
      .busy_o    (port_busy),
      .done_o    (port_done),
      .timeout_o (port_timeout)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      din_d       = din_q;
      wait_d      = wait_q;
      pause_d     = pause_q;
      err_d       = err_q;
      addr_d      = addr_q;
      port_start  = 1'b0;
      port_abort  = 1'b0;
      if (!session) begin
         if (state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            pause_d    = 1'b0;
            wait_d     = 1'b0;
            pend_d     = 1'b0;
            port_abort = 1'b1;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_PAUSE;
               pause_d     = 1'b1;
               err_d       = 1'b0;
               wait_d      = 1'b1;
               cnt_d       = PAUSE_CYCLES;
               pend_d      = ioctl_rd;
               pend_addr_d = ioctl_addr;
            end
            ST_PAUSE: begin
               if (ioctl_rd) begin
                  pend_d      = 1'b1;
                  pend_addr_d = ioctl_addr;
               end
               if (cnt_q <= 8'd1) begin
                  state_d = ST_READY;
                  wait_d  = pend_q || ioctl_rd;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_READY: begin
               if (rd_req) begin
                  if (out_of_range) begin
                     din_d  = FILL;
                     wait_d = 1'b0;
                     pend_d = 1'b0;
                  end else if (port_busy) begin
                     // hold the read until the previous toggle has been answered
                     pend_d      = 1'b1;
                     pend_addr_d = rd_addr;
                     wait_d      = 1'b1;
                  end else begin
                     port_start = 1'b1;
                     addr_d     = BASE_ADDR + {8'd0, rd_addr[15:0]};
                     pend_d     = 1'b0;
                     wait_d     = 1'b1;
                     state_d    = ST_WAIT;
                  end
               end
            end
            default: begin
               if (ioctl_rd) begin
                  pend_d      = 1'b1;
                  pend_addr_d = ioctl_addr;
               end
               if (port_done) begin
                  din_d   = mem_q;
                  wait_d  = pend_d;
                  state_d = ST_READY;
               end else if (port_timeout) begin
                  din_d   = FILL;
                  err_d   = 1'b1;
                  wait_d  = pend_d;
                  state_d = ST_READY;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         din_q       <= FILL;
         wait_q      <= 1'b0;
         pause_q     <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= BASE_ADDR;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         din_q       <= din_d;
         wait_q      <= wait_d;
         pause_q     <= pause_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign core_pause = pause_q;
   assign mem_addr   = addr_q;
   assign err        = err_q;

endmodule

`default_nettype wire
